// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and defaults for the memory arbiter
// Access sequencer states plus default geometry of the sensor memory port.
package mem_arb_pkg;

    localparam int MEM_ARB_MAX_PORTS  = 8;
    localparam int MEM_ARB_DEF_PORTS  = 2;
    localparam int MEM_ARB_DEF_ADDR_W = 8;
    localparam int MEM_ARB_DEF_DATA_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ_ADDR,
        ST_READ_DATA,
        ST_RECOVER
    } state_e;

endpackage

// File: rtl/mem_arb_rr.sv
// rtl/mem_arb_rr.sv - request vector to one-hot grant and winner index
// Round-robin from last+1; MEM_ARB_FIXED_PRIO_EN reduces it to a lowest-index priority encoder.
module mem_arb_rr
    import mem_arb_pkg::*;
#(
    parameter int  NUM_PORTS = MEM_ARB_DEF_PORTS,
    localparam int IDX_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic [NUM_PORTS-1:0] req_i,
`ifndef MEM_ARB_FIXED_PRIO_EN
    input  logic [IDX_W-1:0]     last_i,
`endif
    output logic [NUM_PORTS-1:0] gnt_o,
    output logic [IDX_W-1:0]     idx_o
);

`ifdef MEM_ARB_FIXED_PRIO_EN
    // Walk downwards so the lowest requesting index is the last (winning) assignment.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (req_i[IDX_W'(i)]) begin
                gnt_o             = '0;
                gnt_o[IDX_W'(i)]  = 1'b1;
                idx_o             = IDX_W'(i);
            end
        end
    end
`else
    // Walk from farthest (last itself) to nearest (last+1) so the nearest requester wins.
    always_comb begin
        int p;
        p     = 0;
        gnt_o = '0;
        idx_o = '0;
        for (int k = NUM_PORTS; k >= 1; k--) begin
            p = int'(last_i) + k;
            if (p >= NUM_PORTS) p = p - NUM_PORTS;
            if (req_i[IDX_W'(p)]) begin
                gnt_o            = '0;
                gnt_o[IDX_W'(p)] = 1'b1;
                idx_o            = IDX_W'(p);
            end
        end
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - arbitrates requesters onto the single-port sensor memory
// Round-robin by default; define MEM_ARB_FIXED_PRIO_EN for fixed lowest-index priority.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_PORTS  = MEM_ARB_DEF_PORTS,
    parameter int ADDR_WIDTH = MEM_ARB_DEF_ADDR_W,
    parameter int DATA_WIDTH = MEM_ARB_DEF_DATA_W
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_PORTS-1:0]            req,
    input  logic [NUM_PORTS-1:0]            we,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0] addr,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] wdata,
    output logic [NUM_PORTS-1:0]            done,
    output logic [DATA_WIDTH-1:0]           rdata,
    output logic                            busy,
    output logic [ADDR_WIDTH-1:0]           mem_addr,
    inout  wire  [DATA_WIDTH-1:0]           mem_data,
    output logic                            mem_write,
    output logic                            mem_read
);

    localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    state_e                state_q;
    logic [NUM_PORTS-1:0]  win_q;
    logic [NUM_PORTS-1:0]  done_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [NUM_PORTS-1:0]  gnt;
    logic [IDX_W-1:0]      gnt_idx;
`ifndef MEM_ARB_FIXED_PRIO_EN
    logic [IDX_W-1:0]      last_q;
`endif

    mem_arb_rr #(.NUM_PORTS(NUM_PORTS)) u_rr (
        .req_i  (req),
`ifndef MEM_ARB_FIXED_PRIO_EN
        .last_i (last_q),
`endif
        .gnt_o  (gnt),
        .idx_o  (gnt_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            win_q   <= '0;
            done_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
`ifndef MEM_ARB_FIXED_PRIO_EN
            last_q  <= IDX_W'(NUM_PORTS - 1);
`endif
        end else begin
            done_q <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (|req) begin
                        win_q   <= gnt;
                        addr_q  <= addr[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
                        wdata_q <= wdata[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
`ifndef MEM_ARB_FIXED_PRIO_EN
                        last_q  <= gnt_idx;
`endif
                        state_q <= we[gnt_idx] ? ST_WRITE : ST_READ_ADDR;
                    end
                end
                ST_WRITE: begin
                    done_q  <= win_q;
                    state_q <= ST_RECOVER;
                end
                ST_READ_ADDR: state_q <= ST_READ_DATA;
                ST_READ_DATA: begin
                    rdata_q <= mem_data;
                    done_q  <= win_q;
                    state_q <= ST_RECOVER;
                end
                // RECOVER is the bus turnaround cycle; requests are not looked at here.
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign mem_write = (state_q == ST_WRITE);
    assign mem_read  = (state_q == ST_READ_ADDR) || (state_q == ST_READ_DATA);
    assign mem_addr  = addr_q;
    assign mem_data  = mem_write ? wdata_q : {DATA_WIDTH{1'bz}};
    assign done      = done_q;
    assign rdata     = rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - randomized bench for mem_arbiter against a latency-based reference model
// Honours MEM_ARB_FIXED_PRIO_EN when choosing the expected winner.
module tb_mem_arbiter;

    localparam int N = 2;

    typedef struct {
        bit         w;
        logic [7:0] a;
        logic [7:0] d;
        int         gap;
        int         exp;
    } op_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req;
    logic [1:0]  we;
    logic [15:0] addr;
    logic [15:0] wdata;
    wire  [1:0]  done;
    wire  [7:0]  rdata;
    wire         busy;
    wire  [7:0]  mem_addr;
    wire  [7:0]  mem_data;
    wire         mem_write;
    wire         mem_read;

    logic [7:0] mem_arr [256];
    logic [7:0] ref_mem [256];
    op_t        q0[$];
    op_t        q1[$];
    int         dseq[$];
    int         checks = 0;
    int         errors = 0;
    int         turn_cnt = 0;

    int         m_cnt = 0;
    int         m_w = 0;
    int         m_last = N - 1;
    bit         m_we = 1'b0;
    logic [7:0] m_addr = 8'h00;
    logic [7:0] m_wd = 8'h00;
    logic [7:0] m_rdata = 8'h00;
    logic       prev_read = 1'b0;

    mem_arbiter #(.NUM_PORTS(N), .ADDR_WIDTH(8), .DATA_WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .we        (we),
        .addr      (addr),
        .wdata     (wdata),
        .done      (done),
        .rdata     (rdata),
        .busy      (busy),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .mem_write (mem_write),
        .mem_read  (mem_read)
    );

    always #5 clk = ~clk;

    assign mem_data = mem_read ? mem_arr[mem_addr] : 8'hzz;
    always @(posedge clk) if (mem_write) mem_arr[mem_addr] <= mem_data;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic op_t mk(input int w, input int a, input int d, input int gap, input int exp);
        op_t o;
        o.w   = (w != 0);
        o.a   = 8'(a);
        o.d   = 8'(d);
        o.gap = gap;
        o.exp = exp;
        return o;
    endfunction

    task automatic drive_req();
        req   = 2'b00;
        we    = 2'b00;
        addr  = 16'h0000;
        wdata = 16'h0000;
        if (q0.size() > 0) begin
            we[0] = q0[0].w; addr[7:0] = q0[0].a; wdata[7:0] = q0[0].d;
            req[0] = (q0[0].gap == 0);
        end
        if (q1.size() > 0) begin
            we[1] = q1[0].w; addr[15:8] = q1[0].a; wdata[15:8] = q1[0].d;
            req[1] = (q1[0].gap == 0);
        end
    endtask

    function automatic int pick();
`ifdef MEM_ARB_FIXED_PRIO_EN
        for (int k = 0; k < N; k++) if (req[k]) return k;
`else
        for (int i = 1; i <= N; i++) begin
            int p = (m_last + i) % N;
            if (req[p]) return p;
        end
`endif
        return 0;
    endfunction

    // One clock: advance the model by the edge just taken, compare, then let requesters react.
    task automatic step();
        logic [1:0] e_done;
        int         lat;
        op_t        t;
        @(negedge clk);
        if (rst) begin
            m_cnt = 0; m_last = N - 1; m_rdata = 8'h00; m_addr = 8'h00;
        end else if (m_cnt == 0) begin
            if (req != 2'b00) begin
                m_w = pick(); m_last = m_w; m_we = we[m_w];
                m_addr = addr[m_w*8 +: 8]; m_wd = wdata[m_w*8 +: 8]; m_cnt = 1;
            end
        end else begin
            m_cnt++;
            if (m_cnt == (m_we ? 3 : 4)) m_cnt = 0;
        end
        lat    = m_we ? 2 : 3;
        e_done = 2'b00;
        if (m_cnt != 0 && m_cnt == lat) begin
            e_done[m_w] = 1'b1;
            if (m_we) ref_mem[m_addr] = m_wd;
            else      m_rdata = ref_mem[m_addr];
        end
        check("busy",      32'(busy),      32'(m_cnt != 0));
        check("mem_write", 32'(mem_write), 32'(m_we && m_cnt == 1));
        check("mem_read",  32'(mem_read),  32'(!m_we && (m_cnt == 1 || m_cnt == 2)));
        check("done",      32'(done),      32'(e_done));
        check("rdata",     32'(rdata),     32'(m_rdata));
        check("mem_addr",  32'(mem_addr),  32'(m_addr));
        check("rd_wr_excl", 32'(mem_write & mem_read), 32'd0);
        if (m_we && m_cnt == 1) check("bus_wdata", 32'(mem_data), 32'(m_wd));
        if (mem_write) begin
            turn_cnt++;
            check("turnaround", 32'(prev_read), 32'd0);
        end
        prev_read = mem_read;
        if (done != 2'b00) dseq.push_back(done[1] ? 1 : 0);
        if (e_done[0] && q0.size() > 0) begin
            if (q0[0].exp >= 0) check("readback0", 32'(rdata), 32'(q0[0].exp));
            void'(q0.pop_front());
        end
        if (e_done[1] && q1.size() > 0) begin
            if (q1[0].exp >= 0) check("readback1", 32'(rdata), 32'(q1[0].exp));
            void'(q1.pop_front());
        end
        if (q0.size() > 0 && q0[0].gap > 0) begin t = q0[0]; t.gap--; q0[0] = t; end
        if (q1.size() > 0 && q1[0].gap > 0) begin t = q1[0]; t.gap--; q1[0] = t; end
        drive_req();
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((q0.size() > 0 || q1.size() > 0 || m_cnt != 0) && n < budget) begin
            step();
            n++;
        end
        check("idle_timeout", 32'(q0.size() > 0 || q1.size() > 0 || m_cnt != 0), 32'd0);
    endtask

    initial begin
        int n;
        for (int i = 0; i < 256; i++) begin mem_arr[i] = 8'h00; ref_mem[i] = 8'h00; end

        // Reset with both ports requesting; port 0 must win first afterwards.
        rst = 1'b1;
        q0.push_back(mk(1, 5, 8'h3C, 0, -1));
        q1.push_back(mk(1, 6, 8'hA5, 0, -1));
        drive_req();
        step();
        step();
        rst = 1'b0;
        wait_idle(50);
        check("first_grant", 32'(dseq.size() > 0 ? dseq[0] : 99), 32'd0);

        q1.push_back(mk(0, 5, 0, 0, 8'h3C));
        drive_req();
        wait_idle(50);

        // Both ports streaming writes to 0..15 with data i*3.
        dseq.delete();
        for (int i = 0; i < 8; i++) begin
            q0.push_back(mk(1, 2*i,     3*(2*i),     0, -1));
            q1.push_back(mk(1, 2*i + 1, 3*(2*i + 1), 0, -1));
        end
        drive_req();
        wait_idle(200);
        check("write_count", 32'(dseq.size()), 32'd16);
`ifdef MEM_ARB_FIXED_PRIO_EN
        for (int i = 0; i < 8 && i < dseq.size(); i++) check("fixed_prio", 32'(dseq[i]), 32'd0);
`else
        for (int i = 1; i < dseq.size(); i++) check("alternate", 32'(dseq[i] ^ dseq[i-1]), 32'd1);
`endif
        for (int i = 0; i < 8; i++) begin
            q0.push_back(mk(0, i,     0, 0, 3*i));
            q1.push_back(mk(0, i + 8, 0, 0, 3*(i + 8)));
        end
        drive_req();
        wait_idle(300);

        // Read immediately followed by a write from the same port.
        turn_cnt = 0;
        q0.push_back(mk(0, 5, 0, 0, 15));
        q0.push_back(mk(1, 6, 8'h55, 0, -1));
        drive_req();
        wait_idle(50);
        check("write_after_read", 32'(turn_cnt), 32'd1);

        // Reset landing in READ_DATA aborts the read without a completion.
        q1.push_back(mk(0, 3, 0, 0, 9));
        drive_req();
        n = 0;
        while (!(m_cnt == 2 && !m_we) && n < 20) begin step(); n++; end
        check("reach_read_data", 32'(n < 20), 32'd1);
        rst = 1'b1;
        q1.delete();
        drive_req();
        step();
        rst = 1'b0;
        check("abort_rdata", 32'(rdata), 32'd0);
        check("abort_done",  32'(done),  32'd0);
        step();
        step();

        // Randomized mix with idle gaps.
        for (int i = 0; i < 24; i++) begin
            q0.push_back(mk(int'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
                            int'($urandom_range(0, 255)), int'($urandom_range(0, 3)), -1));
            q1.push_back(mk(int'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
                            int'($urandom_range(0, 255)), int'($urandom_range(0, 3)), -1));
        end
        drive_req();
        wait_idle(1000);
        for (int i = 0; i < 16; i++) q0.push_back(mk(0, i, 0, 0, int'(ref_mem[i])));
        drive_req();
        wait_idle(200);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
